bin_to_rns_9_8_7: RTL and testbench

Forward converter that turns a 9-bit binary integer into residues for moduli {9, 8, 7}, whose dynamic range is 504. It sits upstream of the RNS comparator/arithmetic datapath for that moduli set and produces its a*/b* residue operands. Conversion is bit-serial, MSB first, using Horner's rule: one input bit per cycle, with one conditional subtract per modulus. Input and output each use a valid/ready handshake.

---
 rtl/bin_to_rns_9_8_7_if.sv | 23 ++
 rtl/bin_to_rns_9_8_7.sv | 111 +++++++++++
 tb/tb_bin_to_rns_9_8_7.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/bin_to_rns_9_8_7_if.sv
// Handshake bundle for the binary-to-RNS {9,8,7} forward converter.
// The slave modport is the converter side; master is the producer/consumer side.
interface bin_to_rns_9_8_7_if;
    logic [8:0] x_in;
    logic       valid_in;
    logic       ready_out;
    logic [3:0] r1_out;
    logic [2:0] r2_out;
    logic [2:0] r3_out;
    logic       range_err_out;
    logic       valid_out;
    logic       ready_in;

    modport slave (
        input  x_in, valid_in, ready_in,
        output ready_out, r1_out, r2_out, r3_out, range_err_out, valid_out
    );

    modport master (
        output x_in, valid_in, ready_in,
        input  ready_out, r1_out, r2_out, r3_out, range_err_out, valid_out
    );
endinterface

// File: rtl/bin_to_rns_9_8_7.sv
// Bit-serial (MSB first, Horner's rule) converter from a 9-bit binary value
// to residues mod {9, 8, 7}; one bit per cycle, one conditional subtract per modulus.
module bin_to_rns_9_8_7 #(
    parameter bit ERR_ZERO = 1'b1
) (
    input logic                    clk_in,
    input logic                    rst_n_in,
    bin_to_rns_9_8_7_if.slave      bus
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t     state;
    logic [8:0] shreg;
    logic [3:0] cnt;
    logic       range_err;
    logic [3:0] acc9;
    logic [2:0] acc7;
    logic [2:0] acc8;

    logic [3:0] nxt9;
    logic [2:0] nxt7;
    logic [2:0] nxt8;

    // 2*acc + b never exceeds 2*m - 1, so a single subtract keeps it in range.
    function automatic logic [3:0] step9(input logic [3:0] acc, input logic b);
        logic [4:0] t;
        t = {acc, b};
        if (t >= 5'd9) t = t - 5'd9;
        return t[3:0];
    endfunction

    function automatic logic [2:0] step7(input logic [2:0] acc, input logic b);
        logic [3:0] t;
        t = {acc, b};
        if (t >= 4'd7) t = t - 4'd7;
        return t[2:0];
    endfunction

    assign nxt9 = step9(acc9, shreg[8]);
    assign nxt7 = step7(acc7, shreg[8]);
    assign nxt8 = {acc8[1:0], shreg[8]};

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state             <= IDLE;
            bus.ready_out     <= 1'b1;
            bus.valid_out     <= 1'b0;
            bus.r1_out        <= 4'd0;
            bus.r2_out        <= 3'd0;
            bus.r3_out        <= 3'd0;
            bus.range_err_out <= 1'b0;
            shreg             <= 9'd0;
            cnt               <= 4'd0;
            range_err         <= 1'b0;
            acc9              <= 4'd0;
            acc7              <= 3'd0;
            acc8              <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.valid_in) begin
                        shreg         <= bus.x_in;
                        cnt           <= 4'd0;
                        range_err     <= &bus.x_in[8:3];
                        acc9          <= 4'd0;
                        acc7          <= 3'd0;
                        acc8          <= 3'd0;
                        bus.ready_out <= 1'b0;
                        state         <= CONV;
                    end
                end
                CONV: begin
                    acc9  <= nxt9;
                    acc7  <= nxt7;
                    acc8  <= nxt8;
                    shreg <= {shreg[7:0], 1'b0};
                    cnt   <= cnt + 4'd1;
                    // Outputs change only here, so they stay glitch-free during conversion.
                    if (cnt == 4'd8) begin
                        state             <= DONE;
                        bus.valid_out     <= 1'b1;
                        bus.range_err_out <= range_err;
                        if (range_err && ERR_ZERO) begin
                            bus.r1_out <= 4'd0;
                            bus.r2_out <= 3'd0;
                            bus.r3_out <= 3'd0;
                        end else begin
                            bus.r1_out <= nxt9;
                            bus.r2_out <= nxt8;
                            bus.r3_out <= nxt7;
                        end
                    end
                end
                DONE: begin
                    if (bus.ready_in) begin
                        bus.valid_out <= 1'b0;
                        bus.ready_out <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.ready_out <= 1'b1;
                    bus.valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_rns_9_8_7.sv
// Directed bench for bin_to_rns_9_8_7: one instance per ERR_ZERO setting, shared stimulus.
`timescale 1ns/1ps
module tb_bin_to_rns_9_8_7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bin_to_rns_9_8_7_if bus1 ();
    bin_to_rns_9_8_7_if bus0 ();

    bin_to_rns_9_8_7 #(.ERR_ZERO(1'b1)) dut1 (.clk_in(clk), .rst_n_in(rst_n), .bus(bus1));
    bin_to_rns_9_8_7 #(.ERR_ZERO(1'b0)) dut0 (.clk_in(clk), .rst_n_in(rst_n), .bus(bus0));

    int errors = 0;
    int checks = 0;

    typedef struct {
        int x;
        int r1;
        int r2;
        int r3;
        bit err;
    } vec_t;

    vec_t tbl[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [8:0] x, input logic v, input logic r);
        bus1.x_in = x;  bus1.valid_in = v;  bus1.ready_in = r;
        bus0.x_in = x;  bus0.valid_in = v;  bus0.ready_in = r;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [10:0] pk1();
        return {bus1.r1_out, bus1.r2_out, bus1.r3_out, bus1.range_err_out};
    endfunction

    function automatic logic [10:0] pk0();
        return {bus0.r1_out, bus0.r2_out, bus0.r3_out, bus0.range_err_out};
    endfunction

    function automatic logic [10:0] pack(input int r1, input int r2, input int r3, input bit err);
        return {4'(r1), 3'(r2), 3'(r3), err};
    endfunction

    function automatic logic [10:0] model(input int x, input bit ez);
        bit err;
        err = (x >= 504);
        if (err && ez) return pack(0, 0, 0, 1'b1);
        return pack(x % 9, x % 8, x % 7, err);
    endfunction

    // Accept one operand with ready_in high; returns cycles from acceptance to valid_out.
    task automatic run_one(input logic [8:0] x, output int lat,
                           output logic [10:0] o1, output logic [10:0] o0);
        int n;
        n = 0;
        while (!bus1.ready_out && n < 30) begin tick(); n++; end
        drive(x, 1'b1, 1'b1);
        tick();
        drive(x, 1'b0, 1'b1);
        lat = 0;
        while (!bus1.valid_out && lat < 30) begin tick(); lat++; end
        o1 = pk1();
        o0 = pk0();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [10:0] o1, o0;
        int rdy_low, vld_high;
        logic [8:0] vals [3];
        logic [10:0] exps [3];
        logic [10:0] outs [3];
        int acc_t [3];
        int k, nout, cyc;
        bit pending;

        tbl[0]  = '{0,   0, 0, 0, 1'b0};
        tbl[1]  = '{1,   1, 1, 1, 1'b0};
        tbl[2]  = '{7,   7, 7, 0, 1'b0};
        tbl[3]  = '{63,  0, 7, 0, 1'b0};
        tbl[4]  = '{100, 1, 4, 2, 1'b0};
        tbl[5]  = '{125, 8, 5, 6, 1'b0};
        tbl[6]  = '{200, 2, 0, 4, 1'b0};
        tbl[7]  = '{255, 3, 7, 3, 1'b0};
        tbl[8]  = '{256, 4, 0, 4, 1'b0};
        tbl[9]  = '{503, 8, 7, 6, 1'b0};
        tbl[10] = '{504, 0, 0, 0, 1'b1};
        tbl[11] = '{511, 7, 7, 0, 1'b1};

        // Reset state
        rst_n = 1'b0;
        drive(9'd0, 1'b0, 1'b1);
        tick(); tick();
        check("rst_ready", {31'd0, bus1.ready_out}, 32'd1);
        check("rst_valid", {31'd0, bus1.valid_out}, 32'd0);
        check("rst_outs1", {21'd0, pk1()}, 32'd0);
        check("rst_outs0", {21'd0, pk0()}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single pulse of x=0: ready low 10 cycles, valid high 1 cycle
        drive(9'd0, 1'b1, 1'b1);
        tick();
        drive(9'd0, 1'b0, 1'b1);
        rdy_low = 0; vld_high = 0;
        for (int i = 0; i < 15; i++) begin
            if (!bus1.ready_out) rdy_low++;
            if (bus1.valid_out) begin
                vld_high++;
                check("x0_outs", {21'd0, pk1()}, 32'd0);
            end
            tick();
        end
        check("x0_ready_low_cycles", rdy_low, 10);
        check("x0_valid_cycles", vld_high, 1);

        // Directed table
        foreach (tbl[i]) begin
            run_one(9'(tbl[i].x), lat, o1, o0);
            check($sformatf("tbl_lat_x%0d", tbl[i].x), lat, 9);
            check($sformatf("tbl_ez0_x%0d", tbl[i].x), {21'd0, o0},
                  {21'd0, pack(tbl[i].r1, tbl[i].r2, tbl[i].r3, tbl[i].err)});
            check($sformatf("tbl_ez1_x%0d", tbl[i].x), {21'd0, o1},
                  tbl[i].err ? {21'd0, pack(0, 0, 0, 1'b1)}
                             : {21'd0, pack(tbl[i].r1, tbl[i].r2, tbl[i].r3, 1'b0)});
        end

        // Back-to-back with valid_in held high
        vals[0] = 9'd125; vals[1] = 9'd503; vals[2] = 9'd1;
        exps[0] = pack(8, 5, 6, 1'b0);
        exps[1] = pack(8, 7, 6, 1'b0);
        exps[2] = pack(1, 1, 1, 1'b0);
        foreach (outs[i]) begin outs[i] = '0; acc_t[i] = 0; end
        k = 0; nout = 0; cyc = 0; pending = 1'b0;
        drive(vals[0], 1'b1, 1'b1);
        while ((k < 3 || nout < 3) && cyc < 100) begin
            if (k < 3 && bus1.ready_out && bus1.valid_in) begin
                acc_t[k] = cyc; k++; pending = 1'b1;
            end
            tick(); cyc++;
            if (pending) begin
                if (k < 3) drive(vals[k], 1'b1, 1'b1);
                else       drive(9'd0, 1'b0, 1'b1);
                pending = 1'b0;
            end
            if (bus1.valid_out && nout < 3) begin outs[nout] = pk1(); nout++; end
        end
        drive(9'd0, 1'b0, 1'b1);
        check("b2b_accepts", k, 3);
        check("b2b_outputs", nout, 3);
        check("b2b_gap01", acc_t[1] - acc_t[0], 11);
        check("b2b_gap12", acc_t[2] - acc_t[1], 11);
        for (int i = 0; i < 3; i++)
            check($sformatf("b2b_out%0d", i), {21'd0, outs[i]}, {21'd0, exps[i]});
        tick(); tick();

        // Backpressure: x=200, ready_in low for 5 cycles after valid_out rises
        drive(9'd200, 1'b1, 1'b0);
        tick();
        drive(9'd200, 1'b0, 1'b0);
        lat = 0;
        while (!bus1.valid_out && lat < 30) begin tick(); lat++; end
        check("bp_lat", lat, 9);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp_valid_%0d", i), {31'd0, bus1.valid_out}, 32'd1);
            check($sformatf("bp_ready_%0d", i), {31'd0, bus1.ready_out}, 32'd0);
            check($sformatf("bp_outs_%0d", i), {21'd0, pk1()}, {21'd0, pack(2, 0, 4, 1'b0)});
            if (i < 5) begin
                drive(9'd5, 1'b1, 1'b0);
                tick();
            end
        end
        drive(9'd5, 1'b0, 1'b1);
        tick();
        check("bp_release_valid", {31'd0, bus1.valid_out}, 32'd0);
        check("bp_release_ready", {31'd0, bus1.ready_out}, 32'd1);
        check("bp_release_hold", {21'd0, pk1()}, {21'd0, pack(2, 0, 4, 1'b0)});
        tick();
        check("bp_no_accept", {31'd0, bus1.ready_out}, 32'd1);

        // Reset at E4 during x=300
        drive(9'd300, 1'b1, 1'b1);
        tick();
        drive(9'd300, 1'b0, 1'b1);
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_ready", {31'd0, bus1.ready_out}, 32'd1);
        check("midrst_valid", {31'd0, bus1.valid_out}, 32'd0);
        check("midrst_outs1", {21'd0, pk1()}, 32'd0);
        check("midrst_outs0", {21'd0, pk0()}, 32'd0);
        vld_high = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus1.valid_out) vld_high++;
            tick();
        end
        check("midrst_no_valid", vld_high, 0);
        run_one(9'd7, lat, o1, o0);
        check("post_rst_lat", lat, 9);
        check("post_rst_x7", {21'd0, o1}, {21'd0, pack(7, 7, 0, 1'b0)});

        // Exhaustive in-range sweep, then the out-of-range band
        for (int x = 0; x < 512; x++) begin
            run_one(9'(x), lat, o1, o0);
            check($sformatf("sweep_lat_x%0d", x), lat, 9);
            check($sformatf("sweep_ez1_x%0d", x), {21'd0, o1}, {21'd0, model(x, 1'b1)});
            check($sformatf("sweep_ez0_x%0d", x), {21'd0, o0}, {21'd0, model(x, 1'b0)});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
